// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/mret sequencer driving flush, CSR writes and redirect.
// Optional TRAP_VECTORED_EN: vectored interrupt targets when mtvec[1:0] = 2'b01.
module trap_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        mret,
    input  logic        irq_pc_valid,
    input  logic [31:0] irq_pc,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mie,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        busy,
    output logic        flush,
    output logic        csr_w_en,
    output logic [11:0] csr_w_addr,
    output logic [31:0] csr_w_val,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] mip
);

    typedef enum logic [2:0] {
        IDLE, FLUSH, W_MEPC, W_MCAUSE, W_MSTAT, RET_MSTAT, REDIR
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  sync1_q, sync2_q;
    logic        ret_q, ret_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] pc_q, pc_d;

    logic [31:0] pending;
    logic        irq_take;
    logic [3:0]  irq_code;
    logic [31:0] base_raw, base, trap_tgt;
    logic [31:0] mstat_trap, mstat_ret;

    // {ext, timer, sw} through two flops each
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {irq_ext, irq_timer, irq_sw};
            sync2_q <= sync1_q;
        end
    end

    assign mip = {20'b0, sync2_q[2], 3'b0, sync2_q[1], 3'b0, sync2_q[0], 3'b0};
    assign pending = mip & csr_mie & 32'h0000_0888;
    assign irq_take = csr_mstatus[3] & irq_pc_valid & (pending != 32'b0);

    always_comb begin
        irq_code = 4'd7;
        if (pending[11]) begin
            irq_code = 4'd11;
        end else if (pending[3]) begin
            irq_code = 4'd3;
        end
    end

    always_comb begin
        mstat_trap = csr_mstatus;
        mstat_trap[7] = csr_mstatus[3];
        mstat_trap[3] = 1'b0;
        mstat_trap[12:11] = 2'b11;
        mstat_ret = csr_mstatus;
        mstat_ret[3] = csr_mstatus[7];
        mstat_ret[7] = 1'b1;
        mstat_ret[12:11] = 2'b11;
    end

    assign base_raw = csr_mtvec & ~32'h3;
    assign base = (base_raw == 32'b0) ? RESET_PC : base_raw;

`ifdef TRAP_VECTORED_EN
    // cause_q[31] marks an interrupt; only those are vectored
    assign trap_tgt = (cause_q[31] && csr_mtvec[1:0] == 2'b01)
                    ? base + {26'b0, cause_q[3:0], 2'b00} : base;
`else
    assign trap_tgt = base;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ret_q   <= 1'b0;
            cause_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        cause_d        = cause_q;
        pc_d           = pc_q;
        busy           = 1'b1;
        flush          = 1'b0;
        csr_w_en       = 1'b0;
        csr_w_addr     = 12'h0;
        csr_w_val      = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (exc_valid) begin
                    state_d = FLUSH;
                    ret_d   = 1'b0;
                    cause_d = {28'b0, exc_cause};
                    pc_d    = exc_pc & ~32'h3;
                end else if (mret) begin
                    state_d = FLUSH;
                    ret_d   = 1'b1;
                end else if (irq_take) begin
                    state_d = FLUSH;
                    ret_d   = 1'b0;
                    cause_d = {1'b1, 27'b0, irq_code};
                    pc_d    = irq_pc & ~32'h3;
                end
            end
            FLUSH: begin
                flush   = 1'b1;
                state_d = ret_q ? RET_MSTAT : W_MEPC;
            end
            W_MEPC: begin
                csr_w_en   = 1'b1;
                csr_w_addr = 12'h341;
                csr_w_val  = pc_q;
                state_d    = W_MCAUSE;
            end
            W_MCAUSE: begin
                csr_w_en   = 1'b1;
                csr_w_addr = 12'h342;
                csr_w_val  = cause_q;
                state_d    = W_MSTAT;
            end
            W_MSTAT: begin
                csr_w_en   = 1'b1;
                csr_w_addr = 12'h300;
                csr_w_val  = mstat_trap;
                state_d    = REDIR;
            end
            RET_MSTAT: begin
                csr_w_en   = 1'b1;
                csr_w_addr = 12'h300;
                csr_w_val  = mstat_ret;
                state_d    = REDIR;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = ret_q ? (csr_mepc & ~32'h3) : trap_tgt;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed tests for the trap/mret sequencer.
module tb_trap_ctrl;

    logic        clock;
    logic        reset;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret;
    logic        irq_pc_valid;
    logic [31:0] irq_pc;
    logic        irq_ext, irq_timer, irq_sw;
    logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
    logic        busy, flush, csr_w_en, redirect_valid;
    logic [11:0] csr_w_addr;
    logic [31:0] csr_w_val, redirect_pc, mip;

    int n_checks = 0;
    int n_fail = 0;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] VEC_TGT = 32'h0000_021C;
`else
    localparam logic [31:0] VEC_TGT = 32'h0000_0200;
`endif

    localparam logic [79:0] IDLE_O = 80'h0;
    localparam logic [79:0] FL = {1'b1, 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0};

    trap_ctrl dut (
        .clock(clock), .reset(reset),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .mret(mret), .irq_pc_valid(irq_pc_valid), .irq_pc(irq_pc),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
        .csr_mstatus(csr_mstatus), .csr_mie(csr_mie),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .busy(busy), .flush(flush), .csr_w_en(csr_w_en),
        .csr_w_addr(csr_w_addr), .csr_w_val(csr_w_val),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mip(mip)
    );

    always #5 clock = ~clock;

    logic [79:0] obs;
    assign obs = {busy, flush, csr_w_en, csr_w_addr, csr_w_val,
                  redirect_valid, redirect_pc};

    function automatic logic [79:0] wr(input logic [11:0] a, input logic [31:0] v);
        return {1'b1, 1'b0, 1'b1, a, v, 1'b0, 32'h0};
    endfunction

    function automatic logic [79:0] rd(input logic [31:0] p);
        return {1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, p};
    endfunction

    task automatic test_reset();
        @(negedge clock);
        n_checks++;
        if (obs !== IDLE_O || mip !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h mip %h required 0", obs, mip);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (obs !== IDLE_O) begin
            n_fail++;
            $display("FAIL reset_release: got %h required %h", obs, IDLE_O);
        end
        csr_mtvec = 32'h200;
        csr_mstatus = 32'h8;
        exc_cause = 4'd11;
        exc_pc = 32'h104;
        exc_valid = 1'b1;
        @(negedge clock);
        exc_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (obs !== wr(12'h342, 32'hB)) begin
            n_fail++;
            $display("FAIL reset_pre_mcause: got %h required %h", obs, wr(12'h342, 32'hB));
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== IDLE_O) begin
            n_fail++;
            $display("FAIL reset_mid_seq: got %h required %h", obs, IDLE_O);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== IDLE_O) begin
                n_fail++;
                $display("FAIL reset_abandon[%0d]: got %h required %h", i, obs, IDLE_O);
            end
        end
        csr_mstatus = 32'h0;
    endtask

    task automatic test_exception();
        logic [79:0] e [6];
        e = '{FL, wr(12'h341, 32'h104), wr(12'h342, 32'hB),
              wr(12'h300, 32'h1880), rd(32'h200), IDLE_O};
        csr_mtvec = 32'h200;
        csr_mstatus = 32'h8;
        exc_cause = 4'd11;
        exc_pc = 32'h104;
        exc_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            exc_valid = 1'b0;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL exc_seq[%0d]: got %h required %h", i, obs, e[i]);
            end
        end
        csr_mstatus = 32'h0;
    endtask

    task automatic test_mret();
        logic [79:0] e [4];
        e = '{FL, wr(12'h300, 32'h1888), rd(32'h108), IDLE_O};
        csr_mstatus = 32'h1880;
        csr_mepc = 32'h108;
        mret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            mret = 1'b0;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL mret_seq[%0d]: got %h required %h", i, obs, e[i]);
            end
        end
        csr_mstatus = 32'h0;
    endtask

    task automatic test_irq_gating();
        logic [79:0] e [6];
        e = '{FL, wr(12'h341, 32'h300), wr(12'h342, 32'h8000_0007),
              wr(12'h300, 32'h1880), rd(32'h200), IDLE_O};
        csr_mie = 32'h80;
        csr_mstatus = 32'h0;
        csr_mtvec = 32'h200;
        irq_pc_valid = 1'b1;
        irq_pc = 32'h302;
        irq_timer = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if (busy !== 1'b0 || flush !== 1'b0) begin
                n_fail++;
                $display("FAIL irq_mie_off[%0d]: got busy %b flush %b required 0", i, busy, flush);
            end
        end
        n_checks++;
        if (mip !== 32'h80) begin
            n_fail++;
            $display("FAIL mip_timer: got %h required %h", mip, 32'h80);
        end
        csr_mstatus = 32'h8;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            irq_timer = 1'b0;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL irq_seq[%0d]: got %h required %h", i, obs, e[i]);
            end
        end
        csr_mstatus = 32'h0;
        irq_pc_valid = 1'b0;
    endtask

    task automatic test_priority();
        logic [79:0] e [6];
        logic [79:0] x [6];
        e = '{FL, wr(12'h341, 32'h400), wr(12'h342, 32'h8000_000B),
              wr(12'h300, 32'h1880), rd(32'h200), IDLE_O};
        csr_mie = 32'h888;
        csr_mstatus = 32'h8;
        csr_mtvec = 32'h200;
        irq_pc = 32'h400;
        irq_pc_valid = 1'b0;
        irq_ext = 1'b1;
        irq_sw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL irq_pc_invalid[%0d]: got busy %b required 0", i, busy);
            end
        end
        irq_pc_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            irq_ext = 1'b0;
            irq_sw = 1'b0;
            irq_pc_valid = 1'b0;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL prio_irq[%0d]: got %h required %h", i, obs, e[i]);
            end
        end
        x = '{FL, wr(12'h341, 32'h204), wr(12'h342, 32'h2),
              wr(12'h300, 32'h1880), rd(32'h200), IDLE_O};
        csr_mepc = 32'h500;
        exc_cause = 4'd2;
        exc_pc = 32'h207;
        exc_valid = 1'b1;
        mret = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            exc_valid = 1'b0;
            mret = 1'b0;
            n_checks++;
            if (obs !== x[i]) begin
                n_fail++;
                $display("FAIL prio_exc_mret[%0d]: got %h required %h", i, obs, x[i]);
            end
        end
        csr_mstatus = 32'h0;
    endtask

    task automatic test_vectored();
        logic [79:0] e [5];
        int cyc;
        bit seen;
        e = '{wr(12'h341, 32'h600), wr(12'h342, 32'h8000_0007),
              wr(12'h300, 32'h1880), rd(VEC_TGT), IDLE_O};
        csr_mie = 32'h80;
        csr_mstatus = 32'h8;
        csr_mtvec = 32'h201;
        irq_pc = 32'h600;
        irq_pc_valid = 1'b1;
        irq_timer = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 8) begin
            @(negedge clock);
            cyc++;
            if (flush === 1'b1) seen = 1'b1;
        end
        irq_timer = 1'b0;
        irq_pc_valid = 1'b0;
        n_checks++;
        if (!seen || cyc > 4) begin
            n_fail++;
            $display("FAIL irq_latency: got %0d cycles (seen %0b) required <= 4", cyc, seen);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL vec_irq[%0d]: got %h required %h", i, obs, e[i]);
            end
        end
        exc_cause = 4'd3;
        exc_pc = 32'h700;
        exc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            exc_valid = 1'b0;
        end
        n_checks++;
        if (obs !== rd(32'h200)) begin
            n_fail++;
            $display("FAIL vec_exc_base: got %h required %h", obs, rd(32'h200));
        end
        @(negedge clock);
        csr_mtvec = 32'h3;
        exc_cause = 4'd11;
        exc_pc = 32'h10;
        exc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            exc_valid = 1'b0;
        end
        n_checks++;
        if (obs !== rd(32'h0)) begin
            n_fail++;
            $display("FAIL reset_pc_fallback: got %h required %h", obs, rd(32'h0));
        end
        @(negedge clock);
        csr_mstatus = 32'h0;
    endtask

    task automatic test_back_to_back();
        logic [79:0] e [10];
        e = '{FL, wr(12'h300, 32'h1888), rd(32'h108), IDLE_O, FL,
              wr(12'h341, 32'h800), wr(12'h342, 32'hB),
              wr(12'h300, 32'h1880), rd(32'h200), IDLE_O};
        csr_mstatus = 32'h1880;
        csr_mepc = 32'h10A;
        csr_mtvec = 32'h200;
        exc_cause = 4'd11;
        exc_pc = 32'h800;
        mret = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            mret = 1'b0;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h required %h", i, obs, e[i]);
            end
            if (i == 1) csr_mstatus = 32'h8;
            if (i == 2) exc_valid = 1'b1;
            if (i == 4) exc_valid = 1'b0;
        end
        csr_mstatus = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        exc_valid = 1'b0;
        exc_cause = 4'd0;
        exc_pc = 32'h0;
        mret = 1'b0;
        irq_pc_valid = 1'b0;
        irq_pc = 32'h0;
        irq_ext = 1'b0;
        irq_timer = 1'b0;
        irq_sw = 1'b0;
        csr_mstatus = 32'h0;
        csr_mie = 32'h0;
        csr_mtvec = 32'h0;
        csr_mepc = 32'h0;
        test_reset();
        test_exception();
        test_mret();
        test_irq_gating();
        test_priority();
        test_vectored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
